// File: rtl/pix_corr_pipe.sv
// Dead-pixel corrector for a 3x3 window stream, one pixel per clock.
// Two-stage valid/ready pipeline with per-frame config and corrected-pixel count.
module pix_corr_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   cfg_thr,
    input  logic [3:0]              cfg_min_cnt,
    input  logic [1:0]              cfg_mode,
    input  logic                    in3x3_val,
    output logic                    in3x3_rdy,
    input  logic [9*DATA_WIDTH-1:0] in3x3_data,
    input  logic                    in3x3_sof,
    input  logic                    in3x3_sol,
    input  logic                    in3x3_eol,
    input  logic                    in3x3_eof,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sof,
    output logic                    out_sol,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic [CNT_WIDTH-1:0]    stat_cnt,
    output logic                    stat_vld
);
    localparam int DW = DATA_WIDTH;
    typedef logic [DW+2:0] sum8_t;
    typedef logic [DW+1:0] sum4_t;

    logic                 en1, en2, acc, new_cfg;
    logic                 s1_val, s1_corr, out_corr;
    logic [DW-1:0]        s1_pix;
    logic [3:0]           s1_flg;
    logic [DW-1:0]        thr_q, thr_e;
    logic [3:0]           min_q, min_e;
    logic [1:0]           mode_q, mode_e;
    logic [DW-1:0]        p [9];
    logic [DW-1:0]        diff, rep, pix_nxt;
    logic [3:0]           k;
    sum8_t                sum8;
    sum4_t                sum4;
    logic                 dead;
    logic [CNT_WIDTH-1:0] cnt, base, nxt;

    assign en2       = ~out_val | out_rdy;
    assign en1       = ~s1_val | en2;
    assign in3x3_rdy = en1;
    assign acc       = in3x3_val & en1;
    assign new_cfg   = acc & in3x3_sof;

    // the sof beat itself already uses the freshly sampled config
    assign thr_e  = new_cfg ? cfg_thr     : thr_q;
    assign min_e  = new_cfg ? cfg_min_cnt : min_q;
    assign mode_e = new_cfg ? cfg_mode    : mode_q;

    for (genvar g = 0; g < 9; g++) begin : g_unpack
        assign p[g] = in3x3_data[(8-g)*DW +: DW];
    end

    always_comb begin
        k    = '0;
        sum8 = '0;
        diff = '0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                diff = (p[i] > p[4]) ? p[i] - p[4] : p[4] - p[i];
                if (diff > thr_e)
                    k = k + 4'd1;
                sum8 = sum8 + sum8_t'(p[i]);
            end
        end
        sum4 = sum4_t'(p[1]) + sum4_t'(p[3]) + sum4_t'(p[5]) + sum4_t'(p[7]);
        dead = (min_e != 4'd0) && (k >= min_e) && (mode_e != 2'd0);
        rep  = (mode_e == 2'd2) ? sum4[DW+1:2] : sum8[DW+2:3];
        pix_nxt = dead ? rep : p[4];
    end

    assign base = out_sof ? '0 : cnt;
    assign nxt  = (&base) ? base
                          : base + {{(CNT_WIDTH-1){1'b0}}, out_corr};

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q    <= '0;
            min_q    <= '0;
            mode_q   <= '0;
            s1_val   <= 1'b0;
            s1_pix   <= '0;
            s1_corr  <= 1'b0;
            s1_flg   <= '0;
            out_val  <= 1'b0;
            out_data <= '0;
            out_corr <= 1'b0;
            out_sof  <= 1'b0;
            out_sol  <= 1'b0;
            out_eol  <= 1'b0;
            out_eof  <= 1'b0;
            cnt      <= '0;
            stat_cnt <= '0;
            stat_vld <= 1'b0;
        end else begin
            if (new_cfg) begin
                thr_q  <= cfg_thr;
                min_q  <= cfg_min_cnt;
                mode_q <= cfg_mode;
            end
            if (en1) begin
                s1_val <= in3x3_val;
                if (in3x3_val) begin
                    s1_pix  <= pix_nxt;
                    s1_corr <= dead;
                    s1_flg  <= {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof};
                end
            end
            if (en2) begin
                out_val <= s1_val;
                if (s1_val) begin
                    out_data <= s1_pix;
                    out_corr <= s1_corr;
                    {out_sof, out_sol, out_eol, out_eof} <= s1_flg;
                end
            end
            stat_vld <= 1'b0;
            if (out_val && out_rdy) begin
                if (out_eof) begin
                    stat_cnt <= nxt;
                    stat_vld <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= nxt;
                end
            end
        end
    end
endmodule
